mc_pulse_modulator: RTL and testbench
=====================================

Name: mc_pulse_modulator

Overview:
- Converts a 5-bit motor power command into the pulse width, in clock cycles, that the two-channel servo-pulse generator compares against its frame counter.
- One instance per motor channel. The left-motor channel uses MIRROR=0; the right-motor channel uses MIRROR=1 because that motor is mounted opposite.
- Fractional power is produced by pulse-density dithering across a 12-frame cycle. The external frame-state counter (0..11) selects the frame within that cycle.

Parameters:
- WIDTH, 21, bit width of Pulse.
- NEUTRAL, 150000, stop pulse width in cycles (1.5 ms at 100 MHz).
- SPAN, 50000, full-power deviation from NEUTRAL in cycles (0.5 ms).
- STATES, 12, frames per dither cycle; also the maximum power level.
- MIRROR, 0, when 1 the direction bit is inverted.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- ModInfo  input  5  command. Bit 4 is direction (1 = forward). Bits 3:0 are power level L.
- State  input  5  frame index 0..STATES-1. Driven by the pulse generator and advanced once per refresh frame.
- Pulse  output  WIDTH  registered pulse width in cycles.

Behaviour:
- Reset: when RST_N is low, Pulse = NEUTRAL, the latched command = 0, and the internal first flag = 1. All three take effect asynchronously.
- Command latch: ModInfo is latched on a rising edge where State differs from the registered previous State, or where the first flag is set. The first flag clears on that edge.
- Between State changes, Pulse is held constant even if ModInfo changes. This prevents pulse glitches mid-frame.
- Latency: Pulse reflects the new State and ModInfo on the same rising edge that first samples the changed State, i.e. 1 clock after the change.
- Level: L_eff = min(ModInfo[3:0], STATES), so codes 13..15 are clamped to 12.
- Direction: dir = ModInfo[4] XOR MIRROR. dir=1 means +SPAN; dir=0 means -SPAN.
- Width formula (with DITHER_EN): if State < L_eff, Pulse = NEUTRAL ± SPAN; otherwise Pulse = NEUTRAL. A level of L therefore drives L of 12 frames at full deflection.
- L_eff = 0 gives NEUTRAL regardless of direction.
- State >= STATES (out of range) gives NEUTRAL.
- Arithmetic: unsigned WIDTH bits. The default results span 100000..200000, which fits in 21 bits; no saturation is required.

Optional Feature:
- Macro DITHER_EN.
- Defined: pulse-density dithering as specified in Behaviour.
- Undefined: linear mode. Pulse = NEUTRAL ± floor(L_eff*SPAN/STATES), independent of State except for latch timing. The value comes from a 13-entry constant table, with no runtime divider. Examples: L=6 gives ±25000; L=1 gives ±4166.

Test Plan:
- Reset check: assert RST_N low mid-operation -> Pulse = 150000 immediately, without waiting for a clock edge.
- Dithered forward, MIRROR=0, DITHER_EN: ModInfo=5'b10011 (forward, L=3), step State 0..11 -> Pulse = 200000 for States 0..2 and 150000 for States 3..11, each updated 1 clock after the State change.
- Mirrored and clamped, MIRROR=1, DITHER_EN: ModInfo=5'b11111 (L clamps to 12), any State 0..11 -> Pulse = 100000 in every frame.
- Hold behaviour: with State constant at 0, change ModInfo from 5'b10000 to 5'b11100 -> Pulse stays at 150000; advance State to 1 -> Pulse = 200000.
- Linear mode, DITHER_EN undefined, MIRROR=0: ModInfo=5'b00110 -> Pulse = 125000; ModInfo=5'b10001 -> Pulse = 154166.
- Out-of-range frame index: State=15 with ModInfo=5'b11100 -> Pulse = 150000.

Source files
------------

// File: rtl/mc_pulse_modulator.sv
// Servo pulse-width modulator for one motor channel: maps a 5-bit power command to a pulse width in cycles.
// Define DITHER_EN for 12-frame pulse-density dithering; leave it undefined for linear (table-based) widths.
module mc_pulse_modulator #(
    parameter int WIDTH   = 21,
    parameter int NEUTRAL = 150000,
    parameter int SPAN    = 50000,
    parameter int STATES  = 12,
    parameter int MIRROR  = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       ModInfo,
    input  logic [4:0]       State,
    output logic [WIDTH-1:0] Pulse
);

    // Highest reachable level: the 4-bit code cannot exceed 15 even if STATES does.
    localparam int               LMAX       = (STATES < 15) ? STATES : 15;
    localparam logic [WIDTH-1:0] NEUTRAL_W  = WIDTH'(NEUTRAL);
    localparam logic [4:0]       STATES_W   = 5'(STATES);
    localparam logic             MIRROR_BIT = (MIRROR != 0);

    logic             first;
    logic [4:0]       cmd_q;
    logic [4:0]       state_q;
    logic             latch;
    logic [4:0]       cmd_sel;
    logic [4:0]       state_sel;
    logic [3:0]       level;
    logic             dir;
    logic             in_range;
    logic [WIDTH-1:0] dev;
    logic [WIDTH-1:0] next_pulse;

    function automatic logic [3:0] clamp_level(input logic [3:0] code);
        if (int'(code) > LMAX) begin
            return 4'(LMAX);
        end
        return code;
    endfunction

    function automatic logic [WIDTH-1:0] apply_dev(input logic fwd, input logic [WIDTH-1:0] d);
        return fwd ? (NEUTRAL_W + d) : (NEUTRAL_W - d);
    endfunction

`ifndef DITHER_EN
    // Linear deviations are elaboration-time constants, so no divider is built.
    logic [WIDTH-1:0] lin_tab [0:LMAX];
    for (genvar i = 0; i <= LMAX; i++) begin : g_lin
        assign lin_tab[i] = WIDTH'((i * SPAN) / STATES);
    end
`endif

    assign latch = first || (State != state_q);

    // When not latching, state_q already equals State and cmd_q holds, so Pulse is unchanged.
    always_comb begin
        cmd_sel   = latch ? ModInfo : cmd_q;
        state_sel = latch ? State : state_q;
        level     = clamp_level(cmd_sel[3:0]);
        dir       = cmd_sel[4] ^ MIRROR_BIT;
        in_range  = (state_sel < STATES_W);
        dev       = '0;
`ifdef DITHER_EN
        if (in_range && (state_sel < {1'b0, level})) begin
            dev = WIDTH'(SPAN);
        end
`else
        if (in_range) begin
            dev = lin_tab[level];
        end
`endif
        next_pulse = apply_dev(dir, dev);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Pulse   <= NEUTRAL_W;
            cmd_q   <= '0;
            state_q <= '0;
            first   <= 1'b1;
        end else begin
            state_q <= State;
            if (latch) begin
                cmd_q <= ModInfo;
                first <= 1'b0;
            end
            Pulse <= next_pulse;
        end
    end

endmodule

// File: tb/tb_mc_pulse_modulator.sv
// Directed bench for mc_pulse_modulator: left (MIRROR=0) and right (MIRROR=1) channels share one stimulus.
// Expected widths cover both the dithered and linear builds.
module tb_mc_pulse_modulator;

`ifdef DITHER_EN
    localparam bit DITHER = 1'b1;
`else
    localparam bit DITHER = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [4:0]  ModInfo = 5'd0;
    logic [4:0]  State = 5'd0;
    logic [20:0] pulse_l;
    logic [20:0] pulse_r;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 CLK = ~CLK;

    mc_pulse_modulator #(.MIRROR(0)) u_left (
        .CLK(CLK), .RST_N(RST_N), .ModInfo(ModInfo), .State(State), .Pulse(pulse_l)
    );

    mc_pulse_modulator #(.MIRROR(1)) u_right (
        .CLK(CLK), .RST_N(RST_N), .ModInfo(ModInfo), .State(State), .Pulse(pulse_r)
    );

    task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on a falling edge; the next rising edge samples them; outputs are read on the following falling edge.
    task automatic step(input logic [4:0] m, input logic [4:0] s);
        @(negedge CLK);
        ModInfo = m;
        State   = s;
        @(negedge CLK);
    endtask

    initial begin
        ModInfo = 5'b10011;
        State   = 5'd0;
        #1 RST_N = 1'b0;
        #1;
        check("reset_l", pulse_l, 21'd150000);
        check("reset_r", pulse_r, 21'd150000);

        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("fwd3_s0_l", pulse_l, DITHER ? 21'd200000 : 21'd162500);
        check("fwd3_s0_r", pulse_r, DITHER ? 21'd100000 : 21'd137500);

        for (int s = 1; s < 12; s++) begin
            step(5'b10011, 5'(s));
            check($sformatf("fwd3_s%0d_l", s), pulse_l,
                  DITHER ? ((s < 3) ? 21'd200000 : 21'd150000) : 21'd162500);
            check($sformatf("fwd3_s%0d_r", s), pulse_r,
                  DITHER ? ((s < 3) ? 21'd100000 : 21'd150000) : 21'd137500);
        end

        step(5'b10000, 5'd0);
        check("zero_l", pulse_l, 21'd150000);
        check("zero_r", pulse_r, 21'd150000);
        @(negedge CLK);
        ModInfo = 5'b11100;
        repeat (2) @(negedge CLK);
        check("hold_l", pulse_l, 21'd150000);
        check("hold_r", pulse_r, 21'd150000);
        step(5'b11100, 5'd1);
        check("hold_adv_l", pulse_l, 21'd200000);
        check("hold_adv_r", pulse_r, 21'd100000);

        step(5'b11111, 5'd5);
        check("clamp_s5_l", pulse_l, 21'd200000);
        check("clamp_s5_r", pulse_r, 21'd100000);
        step(5'b11111, 5'd11);
        check("clamp_s11_l", pulse_l, 21'd200000);
        check("clamp_s11_r", pulse_r, 21'd100000);

        step(5'b00110, 5'd3);
        check("rev6_s3_l", pulse_l, DITHER ? 21'd100000 : 21'd125000);
        check("rev6_s3_r", pulse_r, DITHER ? 21'd200000 : 21'd175000);
        step(5'b00110, 5'd7);
        check("rev6_s7_l", pulse_l, DITHER ? 21'd150000 : 21'd125000);
        check("rev6_s7_r", pulse_r, DITHER ? 21'd150000 : 21'd175000);

        step(5'b10001, 5'd0);
        check("fwd1_s0_l", pulse_l, DITHER ? 21'd200000 : 21'd154166);
        check("fwd1_s0_r", pulse_r, DITHER ? 21'd100000 : 21'd145834);

        step(5'b10000, 5'd1);
        check("lvl0_l", pulse_l, 21'd150000);
        check("lvl0_r", pulse_r, 21'd150000);

        step(5'b11100, 5'd15);
        check("oor_l", pulse_l, 21'd150000);
        check("oor_r", pulse_r, 21'd150000);

        @(negedge CLK);
        ModInfo = 5'b11100;
        State   = 5'd2;
        #1;
        check("lat_before_l", pulse_l, 21'd150000);
        @(negedge CLK);
        check("lat_after_l", pulse_l, 21'd200000);
        check("lat_after_r", pulse_r, 21'd100000);

        #2 RST_N = 1'b0;
        #1;
        check("midreset_l", pulse_l, 21'd150000);
        check("midreset_r", pulse_r, 21'd150000);
        State = 5'd0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("first_l", pulse_l, 21'd200000);
        check("first_r", pulse_r, 21'd100000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
